// File: rtl/button_conditioner_pkg.sv
//==============================================================================
// Package : button_conditioner_pkg
// Brief   : Shared defaults and counter-width helper for the button conditioner.
// Rev     : 1.0
//==============================================================================
`default_nettype none

package button_conditioner_pkg;

    localparam int         C_NUM_CH_DEF      = 4;
    localparam int         C_SYNC_STAGES_DEF = 2;
    localparam int         C_STABLE_CNT_DEF  = 4;
    localparam logic [3:0] C_TOGGLE_MASK_DEF = 4'b0010;

    // Bits needed to hold 0..max_val; never narrower than one bit.
    function automatic int CNT_W(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/button_conditioner_if.sv
//==============================================================================
// Interface : button_conditioner_if
// Brief     : Button inputs, sample strobe and conditioned outputs of all channels.
// Rev       : 1.0
//==============================================================================
`default_nettype none

interface button_conditioner_if #(
    parameter int NUM_CH = 4
);
    logic              tick_i;
    logic [NUM_CH-1:0] btn_in_i;
    logic [NUM_CH-1:0] toggle_clr_i;
    logic [NUM_CH-1:0] level_o;
    logic [NUM_CH-1:0] press_o;
    logic [NUM_CH-1:0] release_o;
    logic [NUM_CH-1:0] toggle_o;

    modport master (
        output tick_i, btn_in_i, toggle_clr_i,
        input  level_o, press_o, release_o, toggle_o
    );

    modport slave (
        input  tick_i, btn_in_i, toggle_clr_i,
        output level_o, press_o, release_o, toggle_o
    );
endinterface

`default_nettype wire

// File: rtl/button_conditioner_debounce_channel.sv
//==============================================================================
// Module : debounce_channel
// Brief  : One button: synchroniser, tick-qualified debounce, edge pulses, toggle.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module debounce_channel
    import button_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int STABLE_CNT  = 4,
    parameter bit TOGGLE_EN   = 1'b0
) (
    input  wire logic clkDis,
    input  wire logic rst,
    input  wire logic tick_i,
    input  wire logic btn_i,
    input  wire logic toggle_clr_i,
    output logic      level_o,
    output logic      press_o,
    output logic      release_o,
    output logic      toggle_o
);

    localparam int                 C_CNT_W    = CNT_W(STABLE_CNT);
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(STABLE_CNT - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [C_CNT_W-1:0]     cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic                   toggle_q, toggle_d;
    logic                   w_sync;

    assign w_sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], btn_i};
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        toggle_d  = toggle_q;

        // Any agreeing sample restarts the count, so short glitches never land.
        if (w_sync == level_q) begin
            cnt_d = '0;
        end else if (tick_i) begin
            if (cnt_q == C_CNT_LAST) begin
                cnt_d     = '0;
                level_d   = ~level_q;
                press_d   = ~level_q;
                release_d = level_q;
            end else begin
                cnt_d = cnt_q + C_CNT_W'(1);
            end
        end

        if (!TOGGLE_EN) begin
            toggle_d = 1'b0;
        end else if (toggle_clr_i) begin
            toggle_d = 1'b0;
        end else if (press_d) begin
            toggle_d = ~toggle_q;
        end
    end

    always_ff @(posedge clkDis) begin
        if (rst) begin
            sync_q    <= '0;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            toggle_q  <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            toggle_q  <= toggle_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign toggle_o  = toggle_q;

endmodule

`default_nettype wire

// File: rtl/button_conditioner.sv
//==============================================================================
// Module : button_conditioner
// Brief  : NUM_CH independent debounced push-button channels.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int                NUM_CH      = C_NUM_CH_DEF,
    parameter int                SYNC_STAGES = C_SYNC_STAGES_DEF,
    parameter int                STABLE_CNT  = C_STABLE_CNT_DEF,
    parameter logic [NUM_CH-1:0] TOGGLE_MASK = NUM_CH'(C_TOGGLE_MASK_DEF)
) (
    input  wire logic          clkDis,
    input  wire logic          rst,
    button_conditioner_if.slave bus
);

    logic [NUM_CH-1:0] w_level;
    logic [NUM_CH-1:0] w_press;
    logic [NUM_CH-1:0] w_release;
    logic [NUM_CH-1:0] w_toggle;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .STABLE_CNT  (STABLE_CNT),
            .TOGGLE_EN   (TOGGLE_MASK[i])
        ) u_ch (
            .clkDis       (clkDis),
            .rst          (rst),
            .tick_i       (bus.tick_i),
            .btn_i        (bus.btn_in_i[i]),
            .toggle_clr_i (bus.toggle_clr_i[i]),
            .level_o      (w_level[i]),
            .press_o      (w_press[i]),
            .release_o    (w_release[i]),
            .toggle_o     (w_toggle[i])
        );
    end

    assign bus.level_o   = w_level;
    assign bus.press_o   = w_press;
    assign bus.release_o = w_release;
    assign bus.toggle_o  = w_toggle;

endmodule

`default_nettype wire

// File: tb/tb_button_conditioner.sv
//==============================================================================
// Module : tb_button_conditioner
// Brief  : Scenario tasks plus randomized traffic against a behavioural model.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module tb_button_conditioner;

    localparam int         C_CH     = 4;
    localparam int         C_SYNC   = 2;
    localparam int         C_STABLE = 4;
    localparam logic [3:0] C_MASK   = 4'b0010;

    logic clkDis;
    logic rst;
    int   n_total = 0;
    int   n_bad   = 0;

    button_conditioner_if #(.NUM_CH(C_CH)) bus ();

    button_conditioner #(
        .NUM_CH      (C_CH),
        .SYNC_STAGES (C_SYNC),
        .STABLE_CNT  (C_STABLE),
        .TOGGLE_MASK (C_MASK)
    ) dut (
        .clkDis (clkDis),
        .rst    (rst),
        .bus    (bus)
    );

    initial clkDis = 1'b0;
    always #5 clkDis = ~clkDis;

    // Model: raw-input history per channel, current accepted level, and the
    // number of ticks the delayed input has disagreed with it without a break.
    logic       m_hist [C_CH][C_SYNC];
    int         m_run  [C_CH];
    logic [3:0] m_lvl, m_press, m_rel, m_tog;
    logic [15:0] obs, exp_v;

    task automatic step(input logic r, input logic t, input logic [3:0] b, input logic [3:0] clr);
        logic s_old;
        rst = r; bus.tick_i = t; bus.btn_in_i = b; bus.toggle_clr_i = clr;
        for (int ch = 0; ch < C_CH; ch++) begin
            if (r) begin
                for (int k = 0; k < C_SYNC; k++) m_hist[ch][k] = 1'b0;
                m_run[ch] = 0;
                m_lvl[ch] = 1'b0; m_press[ch] = 1'b0; m_rel[ch] = 1'b0; m_tog[ch] = 1'b0;
            end else begin
                s_old = m_hist[ch][C_SYNC-1];
                for (int k = C_SYNC - 1; k > 0; k--) m_hist[ch][k] = m_hist[ch][k-1];
                m_hist[ch][0] = b[ch];
                m_press[ch] = 1'b0; m_rel[ch] = 1'b0;
                if (s_old == m_lvl[ch]) m_run[ch] = 0;
                else if (t) begin
                    m_run[ch] = m_run[ch] + 1;
                    if (m_run[ch] == C_STABLE) begin
                        m_run[ch] = 0;
                        m_lvl[ch] = s_old;
                        if (s_old) m_press[ch] = 1'b1; else m_rel[ch] = 1'b1;
                    end
                end
                if (!C_MASK[ch]) m_tog[ch] = 1'b0;
                else if (clr[ch]) m_tog[ch] = 1'b0;
                else if (m_press[ch]) m_tog[ch] = ~m_tog[ch];
            end
        end
        @(posedge clkDis);
        #1;
        obs   = {bus.level_o, bus.press_o, bus.release_o, bus.toggle_o};
        exp_v = {m_lvl, m_press, m_rel, m_tog};
    endtask

    task automatic settle_low();
        for (int c = 0; c < 10; c++) step(1'b0, 1'b1, 4'h0, 4'h0);
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            step(1'b1, 1'b1, 4'hF, 4'h0);
            n_total++;
            if (obs !== 16'h0) begin n_bad++; $display("FAIL reset_hold: got %h expected %h", obs, 16'h0); end
        end
        step(1'b0, 1'b1, 4'hF, 4'h0);
        n_total++;
        if (obs !== 16'h0) begin n_bad++; $display("FAIL reset_release: got %h expected %h", obs, 16'h0); end
        for (int c = 0; c < 8; c++) begin
            step(1'b0, 1'b1, 4'hF, 4'h0);
            n_total++;
            if (obs !== exp_v) begin n_bad++; $display("FAIL reset_model: got %h expected %h", obs, exp_v); end
        end
        settle_low();
    endtask

    task automatic test_clean_press();
        for (int c = 0; c < 8; c++) begin
            step(1'b0, 1'b1, 4'b0001, 4'h0);
            n_total++;
            if ({bus.level_o[0], bus.press_o[0]} !== {1'(c >= 5), 1'(c == 5)}) begin
                n_bad++;
                $display("FAIL clean_press c=%0d: got lvl/press %b%b expected %b%b",
                         c, bus.level_o[0], bus.press_o[0], c >= 5, c == 5);
            end
            n_total++;
            if (obs !== exp_v) begin n_bad++; $display("FAIL clean_press_model: got %h expected %h", obs, exp_v); end
        end
        for (int c = 0; c < 8; c++) begin
            step(1'b0, 1'b1, 4'b0000, 4'h0);
            n_total++;
            if ({bus.level_o[0], bus.release_o[0]} !== {1'(c < 5), 1'(c == 5)}) begin
                n_bad++;
                $display("FAIL clean_release c=%0d: got lvl/rel %b%b expected %b%b",
                         c, bus.level_o[0], bus.release_o[0], c < 5, c == 5);
            end
        end
        settle_low();
    endtask

    task automatic test_bounce();
        logic [6:0] pat;
        int n_press, n_rel;
        pat = 7'b0111011;  // applied LSB first: 1,1,0,1,1,1,0
        n_press = 0; n_rel = 0;
        for (int c = 0; c < 17; c++) begin
            step(1'b0, 1'b1, {2'b00, (c < 7) ? pat[c] : 1'b1, 1'b0}, 4'h0);
            n_press += int'(bus.press_o[1]);
            n_rel   += int'(bus.release_o[1]);
            n_total++;
            if (obs !== exp_v) begin n_bad++; $display("FAIL bounce_model: got %h expected %h", obs, exp_v); end
        end
        n_total++;
        if (n_press != 1) begin n_bad++; $display("FAIL bounce_press_count: got %0d expected 1", n_press); end
        n_total++;
        if (n_rel != 0) begin n_bad++; $display("FAIL bounce_release_count: got %0d expected 0", n_rel); end
        settle_low();
    endtask

    task automatic test_tick_gating();
        for (int c = 0; c < 20; c++) begin
            step(1'b0, (c % 4) == 0, 4'b0100, 4'h0);
            n_total++;
            if (bus.level_o[2] !== 1'(c >= 16)) begin
                n_bad++;
                $display("FAIL tick_gating c=%0d: got %b expected %b", c, bus.level_o[2], c >= 16);
            end
        end
        settle_low();
    endtask

    task automatic test_toggle();
        logic [3:0] exp_tog;
        exp_tog = 4'b0101;  // after presses 1..4: 1,0,1,0 (fourth is cleared)
        step(1'b0, 1'b1, 4'h0, 4'b0010);
        n_total++;
        if (bus.toggle_o !== 4'h0) begin n_bad++; $display("FAIL toggle_clear: got %h expected 0", bus.toggle_o); end
        for (int p = 0; p < 4; p++) begin
            for (int c = 0; c < 8; c++) begin
                step(1'b0, 1'b1, 4'b0011, (p == 3 && c == 5) ? 4'b0010 : 4'b0000);
                n_total++;
                if (obs !== exp_v) begin n_bad++; $display("FAIL toggle_model: got %h expected %h", obs, exp_v); end
            end
            n_total++;
            if (bus.toggle_o !== {2'b00, exp_tog[p], 1'b0}) begin
                n_bad++;
                $display("FAIL toggle_press%0d: got %b expected %b", p, bus.toggle_o, {2'b00, exp_tog[p], 1'b0});
            end
            for (int c = 0; c < 8; c++) step(1'b0, 1'b1, 4'h0, 4'h0);
        end
    endtask

    task automatic test_multi_reset();
        for (int c = 0; c < 8; c++) begin
            step(1'b0, 1'b1, 4'hF, 4'h0);
            n_total++;
            if (bus.press_o !== ((c == 5) ? 4'hF : 4'h0)) begin
                n_bad++;
                $display("FAIL multi_press c=%0d: got %h expected %h", c, bus.press_o, (c == 5) ? 4'hF : 4'h0);
            end
        end
        settle_low();
        for (int c = 0; c < 4; c++) step(1'b0, 1'b1, 4'b1000, 4'h0);
        n_total++;
        if (bus.level_o[3] !== 1'b0) begin n_bad++; $display("FAIL mid_count_level: got %b expected 0", bus.level_o[3]); end
        step(1'b1, 1'b1, 4'b1000, 4'h0);
        n_total++;
        if (obs !== 16'h0) begin n_bad++; $display("FAIL mid_count_reset: got %h expected 0", obs); end
        for (int c = 0; c < 10; c++) begin
            step(1'b0, 1'b1, 4'b1000, 4'h0);
            n_total++;
            if (bus.press_o[3] !== 1'(c == 5)) begin
                n_bad++;
                $display("FAIL fresh_press c=%0d: got %b expected %b", c, bus.press_o[3], c == 5);
            end
        end
        settle_low();
    endtask

    task automatic test_random();
        logic [3:0] b, clr, prev_press;
        logic       t, r;
        b = 4'h0; prev_press = 4'h0;
        for (int c = 0; c < 400; c++) begin
            if ($urandom % 6 == 0) b = b ^ 4'(1 << ($urandom % 4));
            t   = ($urandom % 4) != 0;
            clr = ($urandom % 6 == 0) ? 4'($urandom % 16) : 4'h0;
            r   = ($urandom % 150) == 0;
            step(r, t, b, clr);
            n_total++;
            if (obs !== exp_v) begin n_bad++; $display("FAIL random_model c=%0d: got %h expected %h", c, obs, exp_v); end
            n_total++;
            if ((bus.press_o & bus.release_o) !== 4'h0) begin
                n_bad++; $display("FAIL random_press_and_release: got %h expected 0", bus.press_o & bus.release_o);
            end
            n_total++;
            if ((bus.press_o & prev_press) !== 4'h0) begin
                n_bad++; $display("FAIL random_press_width: got %h expected 0", bus.press_o & prev_press);
            end
            prev_press = bus.press_o;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; bus.tick_i = 1'b0; bus.btn_in_i = 4'h0; bus.toggle_clr_i = 4'h0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_tick_gating();
        test_toggle();
        test_multi_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
